// File: rtl/synchro_counter_sr_param_if.sv
// Control/data bundle for synchro_counter_sr_param: count-event inputs, preset/limit values and count outputs.
interface synchro_counter_sr_param_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clk_in;
    logic             count_en;
    logic             up_down;
    logic             clear;
    logic             set;
    logic [WIDTH-1:0] presetValue;
    logic [WIDTH-1:0] limit;
    logic             capture;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic [WIDTH-1:0] captured;

    modport master (
        output clk_in, count_en, up_down, clear, set, presetValue, limit, capture,
        input  out, carry, captured
    );

    modport slave (
        input  clk_in, count_en, up_down, clear, set, presetValue, limit, capture,
        output out, carry, captured
    );
endinterface

// File: rtl/synchro_counter_sr_param.sv
// WIDTH-bit up/down modulus counter stepped by synchronised rising edges of clk_in.
// Optional snapshot register enabled by macro SYNCHRO_COUNTER_CAPTURE_EN.
module synchro_counter_sr_param #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                      qzt_clk,
    input logic                      reset_n,
    synchro_counter_sr_param_if.slave bus
);
    localparam int unsigned TW = WIDTH + 1;

    logic             synced_c;
    logic             edge_prev_q;
    logic             edge_prev_d;
    logic             step_c;
    logic [WIDTH:0]   term_c;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             carry_q;
    logic             carry_d;

    // clk_in synchroniser; zero stages means the line is already qzt-synchronous
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;

            always_comb sync_d = SYNC_STAGES'({sync_q, bus.clk_in});

            always_ff @(posedge qzt_clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sync_d;
            end

            assign synced_c = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign synced_c = bus.clk_in;
        end
    endgenerate

    always_comb begin
        edge_prev_d = synced_c;
        step_c      = synced_c & ~edge_prev_q & bus.count_en;
    end

    // limit of zero selects the full 2^WIDTH range
    always_comb begin
        term_c = {1'b0, {WIDTH{1'b1}}};
        if (bus.limit != '0) term_c = {1'b0, bus.limit} - TW'(1);
    end

    always_comb begin
        out_d   = out_q;
        carry_d = 1'b0;
        if (bus.clear) begin
            out_d = '0;
        end else if (bus.set) begin
            if ({1'b0, bus.presetValue} <= term_c) out_d = bus.presetValue;
            else                                   out_d = term_c[WIDTH-1:0];
        end else if (step_c) begin
            if (bus.up_down) begin
                if ({1'b0, out_q} >= term_c) begin
                    out_d   = '0;
                    carry_d = 1'b1;
                end else begin
                    out_d = out_q + WIDTH'(1);
                end
            end else begin
                if ((out_q == '0) || ({1'b0, out_q} > term_c)) begin
                    out_d   = term_c[WIDTH-1:0];
                    carry_d = 1'b1;
                end else begin
                    out_d = out_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_prev_q <= 1'b0;
            out_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            edge_prev_q <= edge_prev_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
        end
    end

    assign bus.out   = out_q;
    assign bus.carry = carry_q;

`ifdef SYNCHRO_COUNTER_CAPTURE_EN
    logic             cap_synced_c;
    logic             cap_prev_q;
    logic             cap_prev_d;
    logic [WIDTH-1:0] captured_q;
    logic [WIDTH-1:0] captured_d;

    generate
        if (SYNC_STAGES > 0) begin : g_cap_sync
            logic [SYNC_STAGES-1:0] cap_sync_q;
            logic [SYNC_STAGES-1:0] cap_sync_d;

            always_comb cap_sync_d = SYNC_STAGES'({cap_sync_q, bus.capture});

            always_ff @(posedge qzt_clk or negedge reset_n) begin
                if (!reset_n) cap_sync_q <= '0;
                else          cap_sync_q <= cap_sync_d;
            end

            assign cap_synced_c = cap_sync_q[SYNC_STAGES-1];
        end else begin : g_cap_nosync
            assign cap_synced_c = bus.capture;
        end
    endgenerate

    // snapshot takes the pre-step value; clear does not touch it
    always_comb begin
        cap_prev_d = cap_synced_c;
        captured_d = captured_q;
        if (cap_synced_c && !cap_prev_q) captured_d = out_q;
    end

    always_ff @(posedge qzt_clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_prev_q <= 1'b0;
            captured_q <= '0;
        end else begin
            cap_prev_q <= cap_prev_d;
            captured_q <= captured_d;
        end
    end

    assign bus.captured = captured_q;
`else
    logic unused_capture;
    assign unused_capture = bus.capture;
    assign bus.captured   = '0;
`endif

endmodule

// File: tb/tb_synchro_counter_sr_param.sv
// Scoreboard bench for synchro_counter_sr_param: directed scenarios, random traffic and a two-stage cascade.
module tb_synchro_counter_sr_param;
    localparam int unsigned W  = 8;
    localparam int          SS = 2;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        logic [W-1:0] capt;
    } exp_t;

    logic qzt_clk = 1'b0;
    logic reset_n = 1'b0;

    synchro_counter_sr_param_if #(.WIDTH(W)) bif ();
    synchro_counter_sr_param_if #(.WIDTH(W)) lo_if ();
    synchro_counter_sr_param_if #(.WIDTH(W)) hi_if ();

    synchro_counter_sr_param #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .qzt_clk(qzt_clk), .reset_n(reset_n), .bus(bif.slave));
    synchro_counter_sr_param #(.WIDTH(W), .SYNC_STAGES(0)) u_lo (
        .qzt_clk(qzt_clk), .reset_n(reset_n), .bus(lo_if.slave));
    synchro_counter_sr_param #(.WIDTH(W), .SYNC_STAGES(0)) u_hi (
        .qzt_clk(qzt_clk), .reset_n(reset_n), .bus(hi_if.slave));

    assign hi_if.clk_in   = lo_if.carry;
    assign hi_if.count_en = lo_if.carry;

    always #5 qzt_clk = ~qzt_clk;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        sb[$];
    bit          h_clk[$];
    bit          h_cap[$];
    int unsigned m_out, m_carry, m_capt;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic longint cap_exp(longint v);
`ifdef SYNCHRO_COUNTER_CAPTURE_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        m_out = 0; m_carry = 0; m_capt = 0;
        h_clk.delete(); h_cap.delete(); sb.delete();
    endfunction

    // Reference: an edge on clk_in/capture is acted on SS cycles after it is sampled.
    task automatic tick();
        bit syn, prv, csyn, cprv;
        int n;
        int unsigned term, old;
        exp_t e;
        h_clk.push_back(bif.clk_in);
        h_cap.push_back(bif.capture);
        n    = h_clk.size();
        syn  = (n - 1 - SS >= 0) ? h_clk[n-1-SS] : 1'b0;
        prv  = (n - 2 - SS >= 0) ? h_clk[n-2-SS] : 1'b0;
        csyn = (n - 1 - SS >= 0) ? h_cap[n-1-SS] : 1'b0;
        cprv = (n - 2 - SS >= 0) ? h_cap[n-2-SS] : 1'b0;
        term = (bif.limit == 0) ? (1 << W) - 1 : int'(bif.limit) - 1;
        old  = m_out;
        m_carry = 0;
        if (bif.clear) begin
            m_out = 0;
        end else if (bif.set) begin
            m_out = (bif.presetValue <= term) ? bif.presetValue : term;
        end else if (syn && !prv && bif.count_en) begin
            if (bif.up_down) begin
                if (m_out >= term) begin m_out = 0; m_carry = 1; end
                else m_out = m_out + 1;
            end else begin
                if (m_out == 0 || m_out > term) begin m_out = term; m_carry = 1; end
                else m_out = m_out - 1;
            end
        end
        if (csyn && !cprv) m_capt = old;
        @(posedge qzt_clk);
        e.out   = W'(m_out);
        e.carry = m_carry[0];
        e.capt  = W'(cap_exp(m_capt));
        sb.push_back(e);
        #1;
    endtask

    always @(negedge qzt_clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_out", bif.out, e.out);
            check("sb_carry", bif.carry, e.carry);
            check("sb_captured", bif.captured, e.capt);
        end
    end

    task automatic pulse();
        bif.clk_in = 1'b1; tick(); tick();
        bif.clk_in = 1'b0; tick(); tick();
    endtask

    task automatic drain();
        bif.clk_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic load(int unsigned v);
        bif.presetValue = W'(v); bif.set = 1'b1; tick();
        bif.set = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    initial begin
        bif.clk_in = 0; bif.count_en = 1; bif.up_down = 1; bif.clear = 0; bif.set = 0;
        bif.presetValue = 0; bif.limit = W'(10); bif.capture = 0;
        lo_if.clk_in = 0; lo_if.count_en = 1; lo_if.up_down = 1; lo_if.clear = 0; lo_if.set = 0;
        lo_if.presetValue = 0; lo_if.limit = W'(10); lo_if.capture = 0;
        hi_if.up_down = 1; hi_if.clear = 0; hi_if.set = 0;
        hi_if.presetValue = 0; hi_if.limit = W'(10); hi_if.capture = 0;
        model_reset();

        // reset state and first-step latency
        repeat (3) @(posedge qzt_clk);
        #1;
        check("rst_out", bif.out, 0);
        check("rst_carry", bif.carry, 0);
        check("rst_captured", bif.captured, 0);
        reset_n = 1'b1;
        bif.clk_in = 1'b1; tick(); tick();
        check("latency_edge2", bif.out, 0);
        tick();
        check("latency_edge3", bif.out, 1);
        bif.clk_in = 1'b0; tick(); tick();
        repeat (11) pulse();
        drain();
        check("up_12_pulses", bif.out, 2);

        // down count with borrow
        bif.up_down = 1'b0;
        load(2);
        drain();
        repeat (4) pulse();
        drain();
        check("down_4_pulses", bif.out, 8);

        // preset clamp, then clear+set swallowing an edge
        bif.up_down = 1'b1; bif.limit = W'(50);
        load(200);
        check("preset_clamp", bif.out, 49);
        bif.clk_in = 1'b1; tick(); tick();
        bif.clear = 1'b1; bif.set = 1'b1; tick();
        bif.clear = 1'b0; bif.set = 1'b0;
        check("clr_set_out", bif.out, 0);
        check("clr_set_carry", bif.carry, 0);
        tick(); tick();
        check("edge_lost", bif.out, 0);
        drain();

        // full range and limit lowered below the count
        bif.limit = W'(0);
        load(254);
        pulse();
        check("full_255", bif.out, 255);
        pulse();
        check("full_wrap", bif.out, 0);
        bif.limit = W'(10);
        load(7);
        bif.limit = W'(5);
        pulse();
        check("limit_drop_wrap", bif.out, 0);

        // asynchronous reset between clock edges
        bif.limit = W'(10);
        load(6);
        check("pre_reset_out", bif.out, 6);
        @(negedge qzt_clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", bif.out, 0);
        check("async_rst_carry", bif.carry, 0);
        @(posedge qzt_clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        // capture coinciding with a step, then clear
        bif.limit = W'(100);
        load(33);
        bif.clk_in = 1'b1; bif.capture = 1'b1;
        tick(); tick(); tick();
        check("capture_val", bif.captured, cap_exp(33));
        check("capture_step", bif.out, 34);
        bif.clk_in = 1'b0; bif.capture = 1'b0; tick();
        bif.clear = 1'b1; tick();
        bif.clear = 1'b0;
        check("capture_after_clear", bif.captured, cap_exp(33));
        drain();

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            bif.clk_in   = 1'($urandom_range(0, 1));
            bif.capture  = 1'($urandom_range(0, 1));
            bif.count_en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) bif.up_down = ~bif.up_down;
            bif.clear = ($urandom_range(0, 31) == 0);
            bif.set   = ($urandom_range(0, 15) == 0);
            bif.presetValue = W'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 3))
                    0:       bif.limit = W'(0);
                    1:       bif.limit = W'(1);
                    2:       bif.limit = W'(2);
                    default: bif.limit = W'($urandom);
                endcase
            end
            tick();
        end
        bif.clear = 1'b0; bif.set = 1'b0; bif.capture = 1'b0;
        drain();

        // two-stage cascade, decade counters
        for (int i = 1; i <= 25; i++) begin
            lo_if.clk_in = 1'b1;
            @(posedge qzt_clk); #1;
            lo_if.clk_in = 1'b0;
            @(posedge qzt_clk); #1;
            @(posedge qzt_clk); #1;
            check("cascade_lo", lo_if.out, i % 10);
            check("cascade_hi", hi_if.out, i / 10);
        end

        @(negedge qzt_clk);
        #1;
        summary();
        $finish;
    end
endmodule
